fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of branch_control. Consumes its 2-bit PC-source select (muxc5) and owns the program counter.
- Issues one-outstanding-request fetches to instruction memory and delivers instructions with their PC to decode through an IF/ID output register.
- Handles redirect on taken branch or jump-register, flushes in-flight fetches, and holds output under decode stall using a 1-entry skid buffer.

---
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_unit_if                                             |
// | Purpose  : Instruction-memory request/response bus plus the IF/ID    |
// |            delivery port (valid/instr/pc with decode stall).         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   stall;
  logic                   if_valid;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [PC_WIDTH-1:0]    if_pc;

  // Fetch-unit side
  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    input  stall,
    output if_valid, if_instr, if_pc
  );

  // Memory / decode side
  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    output stall,
    input  if_valid, if_instr, if_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_unit                                                |
// | Purpose  : Owns the PC, issues single-outstanding instruction        |
// |            fetches, handles branch/jump-register redirects with      |
// |            stale-response dropping, and delivers instructions to     |
// |            decode through an IF/ID register backed by a 1-entry skid.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fetch_unit #(
  parameter int                   PC_WIDTH    = 16,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic [1:0]          muxc5,
  input  wire logic [PC_WIDTH-1:0] ex_pc,
  input  wire logic [PC_WIDTH-1:0] br_offset,
  input  wire logic [PC_WIDTH-1:0] jr_target,
  fetch_unit_if.master             bus
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing outstanding
    REQ  = 2'd1,  // waiting for a live response
    DROP = 2'd2   // waiting for a response that must be discarded
  } state_t;

  state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]    pc, pc_nxt;
  logic [PC_WIDTH-1:0]    addr, addr_nxt;
  logic                   ifv, ifv_nxt;
  logic [INSTR_WIDTH-1:0] ifi, ifi_nxt;
  logic [PC_WIDTH-1:0]    ifp, ifp_nxt;
  logic                   skv, skv_nxt;
  logic [INSTR_WIDTH-1:0] ski, ski_nxt;
  logic [PC_WIDTH-1:0]    skp, skp_nxt;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    target;
  logic                   to_ifid;
  logic                   capture;

  // Redirect decode; code 11 is reserved and behaves as sequential
  always_comb begin
    redirect = (muxc5 == 2'b01) || (muxc5 == 2'b10);
    target   = (muxc5 == 2'b10) ? jr_target : (ex_pc + br_offset + PC_ONE);
    // A response may land in IF/ID when it is empty or being consumed
    to_ifid  = !ifv || !bus.stall;
  end

  // Next-state, PC, request and IF/ID/skid update logic
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr;
    ifv_nxt   = ifv;
    ifi_nxt   = ifi;
    ifp_nxt   = ifp;
    skv_nxt   = skv;
    ski_nxt   = ski;
    skp_nxt   = skp;
    capture   = 1'b0;

    case (state)
      IDLE: begin
        if (redirect) begin
          pc_nxt = target;
        end else if (!skv) begin
          addr_nxt  = pc;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          // With a simultaneous response the data is simply discarded
          pc_nxt    = target;
          state_nxt = bus.imem_ready ? IDLE : DROP;
        end else if (bus.imem_ready) begin
          capture = 1'b1;
          pc_nxt  = addr + PC_ONE;
          if (to_ifid) begin
            // Skid stays empty, so the next fetch goes out back-to-back
            addr_nxt  = addr + PC_ONE;
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          pc_nxt = target;
        end
        if (bus.imem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect flushes everything; otherwise capture, drain skid, or consume
    if (redirect) begin
      ifv_nxt = 1'b0;
      skv_nxt = 1'b0;
    end else if (capture) begin
      if (to_ifid) begin
        ifv_nxt = 1'b1;
        ifi_nxt = bus.imem_rdata;
        ifp_nxt = addr;
      end else begin
        skv_nxt = 1'b1;
        ski_nxt = bus.imem_rdata;
        skp_nxt = addr;
      end
    end else if (skv && !bus.stall) begin
      ifv_nxt = 1'b1;
      ifi_nxt = ski;
      ifp_nxt = skp;
      skv_nxt = 1'b0;
    end else if (!bus.stall) begin
      ifv_nxt = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      addr  <= RESET_PC;
      ifv   <= 1'b0;
      ifi   <= '0;
      ifp   <= '0;
      skv   <= 1'b0;
      ski   <= '0;
      skp   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      addr  <= addr_nxt;
      ifv   <= ifv_nxt;
      ifi   <= ifi_nxt;
      ifp   <= ifp_nxt;
      skv   <= skv_nxt;
      ski   <= ski_nxt;
      skp   <= skp_nxt;
    end
  end

  assign bus.imem_req  = (state == REQ) || (state == DROP);
  assign bus.imem_addr = addr;
  assign bus.if_valid  = ifv;
  assign bus.if_instr  = ifi;
  assign bus.if_pc     = ifp;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                             |
// | Purpose  : Directed self-checking bench for fetch_unit.              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  muxc5;
  logic [15:0] ex_pc;
  logic [15:0] br_offset;
  logic [15:0] jr_target;

  int checks = 0;
  int passed = 0;

  fetch_unit_if #(.PC_WIDTH(16), .INSTR_WIDTH(32)) bus ();

  fetch_unit #(.PC_WIDTH(16), .INSTR_WIDTH(32), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .muxc5     (muxc5),
    .ex_pc     (ex_pc),
    .br_offset (br_offset),
    .jr_target (jr_target),
    .bus       (bus)
  );

  // Memory returns a word tagged with the requested address
  assign bus.imem_rdata = {16'hC0DE, bus.imem_addr};

  // 10-unit clock
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [15:0] addr,
                         input logic vld);
    chk({tag, ".req"},   32'(bus.imem_req),  32'(req));
    chk({tag, ".addr"},  32'(bus.imem_addr), 32'(addr));
    chk({tag, ".valid"}, 32'(bus.if_valid),  32'(vld));
  endtask

  task automatic chk_out(input string tag, input logic [15:0] pc);
    chk({tag, ".if_pc"},    32'(bus.if_pc), 32'(pc));
    chk({tag, ".if_instr"}, bus.if_instr,   {16'hC0DE, pc});
  endtask

  initial begin
    reset = 1'b1; muxc5 = 2'b00; ex_pc = '0; br_offset = '0; jr_target = '0;
    bus.stall = 1'b0; bus.imem_ready = 1'b0;

    // Reset held two cycles
    cyc(); cyc();
    chk_bus("rst", 1'b0, 16'h0000, 1'b0);
    chk("rst.if_pc",    32'(bus.if_pc), 32'h0);
    chk("rst.if_instr", bus.if_instr,   32'h0);

    // Sequential fetch, zero-wait memory
    reset = 1'b0;
    cyc(); chk_bus("seq0", 1'b1, 16'h0000, 1'b0);
    bus.imem_ready = 1'b1;
    cyc(); chk_bus("seq1", 1'b1, 16'h0001, 1'b1); chk_out("seq1", 16'h0000);
    cyc(); chk_bus("seq2", 1'b1, 16'h0002, 1'b1); chk_out("seq2", 16'h0001);
    cyc(); chk_bus("seq3", 1'b1, 16'h0003, 1'b1); chk_out("seq3", 16'h0002);

    // Stall for 4 cycles: addr 3 goes to skid, no new request
    bus.stall = 1'b1;
    cyc(); chk_bus("stl0", 1'b0, 16'h0003, 1'b1); chk_out("stl0", 16'h0002);
    bus.imem_ready = 1'b0;
    cyc(); chk_bus("stl1", 1'b0, 16'h0003, 1'b1); chk_out("stl1", 16'h0002);
    cyc(); chk_bus("stl2", 1'b0, 16'h0003, 1'b1); chk_out("stl2", 16'h0002);
    cyc(); chk_bus("stl3", 1'b0, 16'h0003, 1'b1); chk_out("stl3", 16'h0002);
    bus.stall = 1'b0;
    cyc(); chk_bus("skid", 1'b0, 16'h0003, 1'b1); chk_out("skid", 16'h0003);
    cyc(); chk_bus("res4", 1'b1, 16'h0004, 1'b0);

    // Jump-register together with the addr-4 response: response discarded
    muxc5 = 2'b10; jr_target = 16'h0040; bus.imem_ready = 1'b1;
    cyc(); chk_bus("jrsim", 1'b0, 16'h0004, 1'b0);
    muxc5 = 2'b00; bus.imem_ready = 1'b0;
    cyc(); chk_bus("jr40", 1'b1, 16'h0040, 1'b0);
    bus.imem_ready = 1'b1;
    cyc(); chk_bus("jr41", 1'b1, 16'h0041, 1'b1); chk_out("jr41", 16'h0040);

    // Jump to 7 with no response: drop the addr-0x41 fetch
    muxc5 = 2'b10; jr_target = 16'h0007; bus.imem_ready = 1'b0;
    cyc(); chk_bus("jr7a", 1'b1, 16'h0041, 1'b0);
    muxc5 = 2'b00; bus.imem_ready = 1'b1;
    cyc(); chk_bus("jr7b", 1'b0, 16'h0041, 1'b0);
    bus.imem_ready = 1'b0;
    cyc(); chk_bus("jr7c", 1'b1, 16'h0007, 1'b0);

    // Taken branch while REQ at 7: ex_pc 5 + 1 + 3 = 9
    muxc5 = 2'b01; ex_pc = 16'h0005; br_offset = 16'h0003;
    cyc(); chk_bus("br0", 1'b1, 16'h0007, 1'b0);
    muxc5 = 2'b00;
    cyc(); chk_bus("br1", 1'b1, 16'h0007, 1'b0);
    bus.imem_ready = 1'b1;
    cyc(); chk_bus("br2", 1'b0, 16'h0007, 1'b0);
    bus.imem_ready = 1'b0;
    cyc(); chk_bus("br3", 1'b1, 16'h0009, 1'b0);
    bus.imem_ready = 1'b1;
    cyc(); chk_bus("br4", 1'b1, 16'h000A, 1'b1); chk_out("br4", 16'h0009);

    // Wrap-around via jr to 0xFFFF
    muxc5 = 2'b10; jr_target = 16'hFFFF; bus.imem_ready = 1'b0;
    cyc(); chk_bus("wr0", 1'b1, 16'h000A, 1'b0);
    muxc5 = 2'b00; bus.imem_ready = 1'b1;
    cyc(); chk_bus("wr1", 1'b0, 16'h000A, 1'b0);
    bus.imem_ready = 1'b0;
    cyc(); chk_bus("wr2", 1'b1, 16'hFFFF, 1'b0);
    bus.imem_ready = 1'b1;
    cyc(); chk_bus("wr3", 1'b1, 16'h0000, 1'b1); chk_out("wr3", 16'hFFFF);
    cyc(); chk_bus("wr4", 1'b1, 16'h0001, 1'b1); chk_out("wr4", 16'h0000);

    // Negative branch offset: 0xFFFE + 1 - 3 = 0xFFFC, with simultaneous response
    muxc5 = 2'b01; ex_pc = 16'hFFFE; br_offset = 16'hFFFD;
    cyc(); chk_bus("nb0", 1'b0, 16'h0001, 1'b0);
    muxc5 = 2'b00; bus.imem_ready = 1'b0;
    cyc(); chk_bus("nb1", 1'b1, 16'hFFFC, 1'b0);
    bus.imem_ready = 1'b1;
    cyc(); chk_bus("nb2", 1'b1, 16'hFFFD, 1'b1); chk_out("nb2", 16'hFFFC);

    // Reset during REQ with a response in the same cycle
    reset = 1'b1;
    cyc(); chk_bus("mrst", 1'b0, 16'h0000, 1'b0);
    chk("mrst.if_pc",    32'(bus.if_pc), 32'h0);
    chk("mrst.if_instr", bus.if_instr,   32'h0);
    reset = 1'b0; bus.imem_ready = 1'b0;
    cyc(); chk_bus("prst", 1'b1, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
